powlib_unpack: RTL and testbench
================================

POWLIB_UNPACK -- requirements
Module: powlib_unpack

Interface
REQ-001 SHALL have parameter W, default 16: narrow output word width in bits; legal W >= 1.
REQ-002 SHALL have parameter M, default 4: narrow beats per wide input word; legal M >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port wrdata, input, W*M: wide word from upstream source, typically a powlib_sfifo read port.
REQ-006 SHALL have port wrvld, input, 1: wrdata valid.
REQ-007 SHALL have port wrrdy, output, 1: block accepts wrdata this cycle.
REQ-008 SHALL have port rddata, output, W: current narrow beat.
REQ-009 SHALL have port rdvld, output, 1: rddata valid.
REQ-010 SHALL have port rdrdy, input, 1: downstream accepts rddata this cycle.

Function
REQ-011 SHALL hold one wide word in a holding register, a beat counter cnt of width max(1, clog2(M)), and a one-bit state: EMPTY or LOADED.
REQ-012 SHALL define wrinc = wrvld && wrrdy and rdinc = rdvld && rdrdy; a transfer occurs only on these terms.
REQ-013 SHALL drive rdvld = 1 exactly in state LOADED, registered-state-derived with no combinational path from wrvld.
REQ-014 SHALL drive rddata = holding[cnt*W +: W]: beat 0 is the least-significant W bits, beat M-1 the most-significant.
REQ-015 SHALL drive wrrdy = (state==EMPTY) || (rdrdy && cnt==M-1), allowing next-word accept on the same cycle the last beat is consumed.
REQ-016 On wrinc: SHALL load wrdata into holding, set cnt=0, and enter LOADED.
REQ-017 On rdinc with cnt<M-1: SHALL increment cnt by 1 and stay LOADED.
REQ-018 On rdinc with cnt==M-1 and no wrinc: SHALL set cnt=0 and enter EMPTY.
REQ-019 On rdinc with cnt==M-1 and wrinc in the same cycle: REQ-016 takes effect; the block stays LOADED with cnt=0.
REQ-020 With rdvld=1 and rdrdy=0: rddata, cnt and holding SHALL stay unchanged; no beat is skipped or repeated.
REQ-021 Latency SHALL be 1 cycle: a wide word accepted at edge n gives beat 0 with rdvld=1 in the cycle after edge n.
REQ-022 Throughput SHALL be one narrow beat per cycle, sustained indefinitely, with wrvld and rdrdy held high; M narrow beats per wide word with no bubbles.
REQ-023 SHALL never accept a wide word while beats 0..M-2 of the current word are pending.

Reset
REQ-024 With rst=1 at a rising edge: state SHALL become EMPTY and cnt=0, so rdvld=0 and wrrdy=1 in the following cycle; holding content is don't-care.
REQ-025 rst SHALL take priority over wrinc and rdinc in the same cycle; a partly emitted word is discarded and nothing is accepted on that edge.
REQ-026 rddata SHALL be ignored by downstream while rdvld=0; no reset value is required on rddata.

Verification
REQ-027 W=16,M=4, single word 0x4444_3333_2222_1111 with rdrdy=1 -> beats 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles starting 1 cycle after accept; then rdvld=0.
REQ-028 Back-to-back: words A,B presented continuously, rdrdy=1 -> 8 consecutive valid beats; wrrdy=1 only on the cycle beat A3 is consumed; no bubble between A3 and B0.
REQ-029 Backpressure: rdrdy toggled 1,0,0,1,... during a word -> rddata held stable while rdrdy=0; the beat order is exactly 0..3 with no duplicate or skip; wrrdy=0 throughout until the last beat.
REQ-030 Reset mid-word: assert rst after beat 1 is consumed -> next cycle rdvld=0, wrrdy=1; a new word then starts at beat 0.
REQ-031 Source starvation: wrvld=0 after one word -> rdvld falls the cycle after the last beat; wrrdy remains 1.
REQ-032 Integration: powlib_sfifo (W=64,D=8) read port drives this block (W=16,M=4) -> the random wide-word stream is reproduced as a narrow stream with a scoreboard match, under random rdrdy.

Source files
------------

// File: rtl/powlib_unpack_if.sv
// Handshake bundle for powlib_unpack: wide-word write side and narrow-beat read side.
// The slave modport is the unpacker itself; master is its environment.
interface powlib_unpack_if #(
   parameter int W = 16,
   parameter int M = 4
);
   logic [W*M-1:0] wrdata;
   logic           wrvld;
   logic           wrrdy;
   logic [W-1:0]   rddata;
   logic           rdvld;
   logic           rdrdy;

   modport master (
      output wrdata, wrvld, rdrdy,
      input  wrrdy, rddata, rdvld
   );

   modport slave (
      input  wrdata, wrvld, rdrdy,
      output wrrdy, rddata, rdvld
   );
endinterface

// File: rtl/powlib_unpack.sv
// Width down-converter: splits each W*M-bit word into M W-bit beats, LSB beat first.
// Holds one word at a time and can take the next word on the cycle its last beat leaves.
module powlib_unpack #(
   parameter int W = 16,
   parameter int M = 4
) (
   input  logic            clk,
   input  logic            rst,
   powlib_unpack_if.slave  bus
);
   localparam int CW = ($clog2(M) > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(M - 1);

   localparam logic [0:0] ST_EMPTY  = 1'b0;
   localparam logic [0:0] ST_LOADED = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [M-1:0][W-1:0] hold_q, hold_d;

   logic last;
   logic wrinc;
   logic rdinc;

   assign last  = (cnt_q == LAST_BEAT);
   assign wrinc = bus.wrvld && bus.wrrdy;
   assign rdinc = bus.rdvld && bus.rdrdy;

   // rdvld comes straight from state; wrrdy may look at rdrdy to refill without a bubble.
   assign bus.rdvld  = (state_q == ST_LOADED);
   assign bus.wrrdy  = (state_q == ST_EMPTY) || (bus.rdrdy && last);
   assign bus.rddata = hold_q[cnt_q];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (wrinc) begin
         hold_d  = bus.wrdata;
         cnt_d   = '0;
         state_d = ST_LOADED;
      end else if (rdinc) begin
         if (last) begin
            cnt_d   = '0;
            state_d = ST_EMPTY;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the data holding register is deliberately left out of reset; rdvld qualifies it.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end
endmodule

// File: tb/tb_powlib_unpack.sv
// Self-checking bench for powlib_unpack: directed scenarios plus a long random run,
// all scored against a queue model of the narrow beat stream.
module tb_powlib_unpack;
   localparam int W = 16;
   localparam int M = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   powlib_unpack_if #(.W(W), .M(M)) bus ();

   powlib_unpack #(.W(W), .M(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0]   exp_q[$];
   logic [W*M-1:0] src_q[$];

   logic obs_vld;
   logic obs_rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
   task automatic step(input logic r, input logic src_en, input logic rr);
      logic           exp_vld;
      logic           exp_rdy;
      logic           wi;
      logic           ri;
      logic [W*M-1:0] word;
      rst       = r;
      bus.rdrdy = rr;
      bus.wrvld = src_en && (src_q.size() > 0);
      bus.wrdata = (src_q.size() > 0) ? src_q[0] : '0;
      @(negedge clk);
      exp_vld = (exp_q.size() > 0);
      exp_rdy = (exp_q.size() == 0) || (rr && exp_q.size() == 1);
      check("rdvld", 64'(bus.rdvld), 64'(exp_vld));
      check("wrrdy", 64'(bus.wrrdy), 64'(exp_rdy));
      if (exp_vld) check("rddata", 64'(bus.rddata), 64'(exp_q[0]));
      obs_vld = bus.rdvld;
      obs_rdy = bus.wrrdy;
      wi = bus.wrvld && exp_rdy;
      ri = exp_vld && rr;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
      end else begin
         if (ri) void'(exp_q.pop_front());
         if (wi) begin
            word = src_q.pop_front();
            for (int k = 0; k < M; k++) exp_q.push_back(word[k*W +: W]);
         end
      end
      #1;
   endtask

   initial begin
      int nbeats;
      int nrdy;
      logic [1:0] bp_pat [4];
      bp_pat[0] = 2'd1; bp_pat[1] = 2'd0; bp_pat[2] = 2'd0; bp_pat[3] = 2'd1;

      rst        = 1'b1;
      bus.wrvld  = 1'b0;
      bus.wrdata = '0;
      bus.rdrdy  = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Reset state
      step(1'b0, 1'b0, 1'b1);
      check("reset_rdvld", 64'(obs_vld), 64'd0);
      check("reset_wrrdy", 64'(obs_rdy), 64'd1);

      // Single word, full-rate drain, then starvation
      src_q.push_back(64'h4444_3333_2222_1111);
      step(1'b0, 1'b1, 1'b1);
      check("single_accept_vld", 64'(obs_vld), 64'd0);
      nbeats = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (obs_vld) nbeats++;
      end
      check("single_beats", 64'(nbeats), 64'd4);
      step(1'b0, 1'b1, 1'b1);
      check("starve_rdvld", 64'(obs_vld), 64'd0);
      check("starve_wrrdy", 64'(obs_rdy), 64'd1);

      // Back-to-back words A,B with no bubble
      src_q.push_back(64'hAAA3_AAA2_AAA1_AAA0);
      src_q.push_back(64'hBBB3_BBB2_BBB1_BBB0);
      step(1'b0, 1'b1, 1'b1);
      nbeats = 0;
      nrdy   = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (obs_vld) nbeats++;
         if (obs_rdy && i < 7) nrdy++;
      end
      check("b2b_beats", 64'(nbeats), 64'd8);
      check("b2b_wrrdy_count", 64'(nrdy), 64'd1);
      step(1'b0, 1'b1, 1'b1);
      check("b2b_drained", 64'(obs_vld), 64'd0);

      // Backpressure 1,0,0,1 with a second word waiting at the input
      src_q.push_back(64'hCCC3_CCC2_CCC1_CCC0);
      src_q.push_back(64'hDDD3_DDD2_DDD1_DDD0);
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40 && (exp_q.size() > 0 || src_q.size() > 0); i++)
         step(1'b0, 1'b1, bp_pat[i % 4][0]);
      check("bp_drained", 64'(exp_q.size() + src_q.size()), 64'd0);

      // Reset after beat 1 is consumed
      src_q.push_back(64'hEEE3_EEE2_EEE1_EEE0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("midrst_rdvld", 64'(obs_vld), 64'd0);
      check("midrst_wrrdy", 64'(obs_rdy), 64'd1);
      src_q.push_back(64'hFFF3_FFF2_FFF1_FFF0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);

      // Random stream with random source gaps, backpressure and rare resets
      for (int i = 0; i < 3000; i++) begin
         if (src_q.size() < 3 && $urandom_range(0, 3) != 0)
            src_q.push_back({$urandom(), $urandom()});
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 60 && (exp_q.size() > 0 || src_q.size() > 0); i++)
         step(1'b0, 1'b1, 1'b1);
      check("final_drained", 64'(exp_q.size() + src_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
